// File: rtl/draw_controller_pkg.sv
// Shared constants for the draw controller and its datapath: FSM encoding,
// default screen/car/verge geometry and pixel colour codes.
package draw_controller_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_BG_BLACK = 3'd1;
  localparam logic [2:0] S_BG_LEFT  = 3'd2;
  localparam logic [2:0] S_BG_RIGHT = 3'd3;
  localparam logic [2:0] S_CAR      = 3'd4;
  localparam logic [2:0] S_WAIT     = 3'd5;
  localparam logic [2:0] S_ERASE    = 3'd6;
  localparam logic [2:0] S_MOVE     = 3'd7;

  localparam int DEF_SCR_W = 160;
  localparam int DEF_SCR_H = 120;
  localparam int DEF_GRN_W = 20;
  localparam int DEF_CAR_W = 8;
  localparam int DEF_CAR_H = 12;
  localparam int DEF_CAR_Y = 100;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_GREEN = 3'b010;
  localparam logic [2:0] COL_CAR   = 3'b100;

  // States that sweep a rectangle and strobe plot every cycle.
  function automatic logic is_draw(input logic [2:0] s);
    return (s != S_IDLE) && (s != S_WAIT) && (s != S_MOVE);
  endfunction

endpackage

// File: rtl/draw_controller_if.sv
// Controller <-> datapath bundle: sweep counters in, phase selects,
// strobes and region origin out.
interface draw_controller_if;
  logic [7:0] xcounter;
  logic [7:0] ycounter;
  logic       draw_bg_black;
  logic       draw_bg_green_left;
  logic       draw_bg_green_right;
  logic       draw_car;
  logic       erase;
  logic       drive;
  logic       plot;
  logic       inc;
  logic       done;
  logic [7:0] xpoint;
  logic [7:0] ypoint;

  modport master (
    input  xcounter, ycounter,
    output draw_bg_black, draw_bg_green_left, draw_bg_green_right,
           draw_car, erase, drive, plot, inc, done, xpoint, ypoint
  );

  modport slave (
    output xcounter, ycounter,
    input  draw_bg_black, draw_bg_green_left, draw_bg_green_right,
           draw_car, erase, drive, plot, inc, done, xpoint, ypoint
  );
endinterface

// File: rtl/draw_controller_sweep_compare.sv
// End-of-row / end-of-region detector for the datapath raster sweep.
module sweep_compare (
  input  logic       i_en,
  input  logic [7:0] i_x,
  input  logic [7:0] i_y,
  input  logic [7:0] i_w_m1,
  input  logic [7:0] i_h_m1,
  output logic       o_inc,
  output logic       o_done
);
  logic w_row_end;

  assign w_row_end = i_en && (i_x == i_w_m1);
  assign o_inc     = w_row_end && (i_y <  i_h_m1);
  assign o_done    = w_row_end && (i_y == i_h_m1);
endmodule

// File: rtl/draw_controller.sv
// Screen/car drawing sequencer: paints background and verges, then animates
// the car one step per frame tick by erase / move / redraw.
module draw_controller
  import draw_controller_pkg::*;
#(
  parameter int SCR_W = DEF_SCR_W,
  parameter int SCR_H = DEF_SCR_H,
  parameter int GRN_W = DEF_GRN_W,
  parameter int CAR_W = DEF_CAR_W,
  parameter int CAR_H = DEF_CAR_H,
  parameter int CAR_Y = DEF_CAR_Y
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic frame_tick,
  input  logic left_key,
  input  logic right_key,
  output logic busy,
  draw_controller_if.master dp
);
  localparam logic [7:0] CAR_X0  = 8'((SCR_W - CAR_W) / 2);
  localparam logic [7:0] X_MIN   = 8'(GRN_W);
  localparam logic [7:0] X_MAX   = 8'(SCR_W - GRN_W - CAR_W);
  localparam logic [7:0] RGT_X   = 8'(SCR_W - GRN_W);

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic [7:0] r_car_x;
  logic       r_pend;
  logic       w_draw;
  logic       w_done;
  logic       w_inc;
  logic [7:0] w_w_m1;
  logic [7:0] w_h_m1;
  logic [7:0] w_ox;
  logic [7:0] w_oy;

  assign w_draw = is_draw(r_state);

  always_comb begin
    w_w_m1 = 8'd0;
    w_h_m1 = 8'd0;
    w_ox   = 8'd0;
    w_oy   = 8'd0;
    case (r_state)
      S_BG_BLACK: begin w_w_m1 = 8'(SCR_W - 1); w_h_m1 = 8'(SCR_H - 1); end
      S_BG_LEFT:  begin w_w_m1 = 8'(GRN_W - 1); w_h_m1 = 8'(SCR_H - 1); end
      S_BG_RIGHT: begin
        w_w_m1 = 8'(GRN_W - 1); w_h_m1 = 8'(SCR_H - 1); w_ox = RGT_X;
      end
      S_CAR, S_ERASE: begin
        w_w_m1 = 8'(CAR_W - 1); w_h_m1 = 8'(CAR_H - 1);
        w_ox   = r_car_x;       w_oy   = 8'(CAR_Y);
      end
      default: ;
    endcase
  end

  sweep_compare u_cmp (
    .i_en   (w_draw),
    .i_x    (dp.xcounter),
    .i_y    (dp.ycounter),
    .i_w_m1 (w_w_m1),
    .i_h_m1 (w_h_m1),
    .o_inc  (w_inc),
    .o_done (w_done)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start)  w_next = S_BG_BLACK;
      S_BG_BLACK: if (w_done) w_next = S_BG_LEFT;
      S_BG_LEFT:  if (w_done) w_next = S_BG_RIGHT;
      S_BG_RIGHT: if (w_done) w_next = S_CAR;
      S_CAR:      if (w_done) w_next = S_WAIT;
      S_WAIT:     if (r_pend) w_next = S_ERASE;
      S_ERASE:    if (w_done) w_next = S_MOVE;
      S_MOVE:                 w_next = S_CAR;
      default:                w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_car_x <= CAR_X0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_next;
      // Consumption wins over a coincident tick: that tick arrives while pending.
      if (r_state == S_WAIT && r_pend)
        r_pend <= 1'b0;
      else if (frame_tick)
        r_pend <= 1'b1;
      if (r_state == S_MOVE) begin
        if (left_key && !right_key && r_car_x > X_MIN)
          r_car_x <= r_car_x - 8'd1;
        else if (right_key && !left_key && r_car_x < X_MAX)
          r_car_x <= r_car_x + 8'd1;
      end
    end
  end

  assign dp.draw_bg_black       = (r_state == S_BG_BLACK);
  assign dp.draw_bg_green_left  = (r_state == S_BG_LEFT);
  assign dp.draw_bg_green_right = (r_state == S_BG_RIGHT);
  assign dp.draw_car            = (r_state == S_CAR);
  assign dp.erase               = (r_state == S_ERASE);
  assign dp.drive               = (r_state == S_MOVE);
  assign dp.plot                = w_draw;
  assign dp.inc                 = w_inc;
  assign dp.done                = w_done;
  assign dp.xpoint              = w_ox;
  assign dp.ypoint              = w_oy;
  assign busy                   = (r_state != S_IDLE) && (r_state != S_WAIT);

endmodule
